// File: rtl/interl_ctrl.sv
// interl_ctrl: ping-pong block-interleaver controller.
//
// Drives an external 1-bit RAM with a single write port and an
// asynchronous read port. The RAM is split into two banks of
// 2**(ADDR_WIDTH-1) bits each. Serial input bits are written row-major
// into the current write bank. A bank that holds a complete block is read
// column-major and streamed out through a valid/ready register stage.
//
// The RAM writes on every clock edge. On cycles with no accepted input,
// the write address is parked at the top RAM location (PARK). Because a
// block is smaller than a bank, PARK never holds data.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   in_valid, in_bit  serial input bit with its valid strobe
//   in_ready          input accepted when in_valid && in_ready
//   out_valid/out_bit/out_last/out_ready
//                     interleaved output stream; out_last marks the
//                     final bit of a block
//   wr_ram_counter    RAM write address
//   ram_bit_data      RAM write data
//   r_ram_counter     RAM read address
//   ram_read_data     asynchronous RAM read data at r_ram_counter
//   bank_full         per-bank "complete unread block" flags
module interl_ctrl #(
  parameter int ADDR_WIDTH = 14,
  parameter int ROWS       = 64,
  parameter int COLS       = 120
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_bit,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic                  out_bit,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] wr_ram_counter,
  output logic                  ram_bit_data,
  output logic [ADDR_WIDTH-1:0] r_ram_counter,
  input  logic                  ram_read_data,
  output logic [1:0]            bank_full
);

  localparam int OW   = ADDR_WIDTH - 1;
  localparam int N    = ROWS * COLS;
  localparam int BANK = 2 ** OW;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [ADDR_WIDTH-1:0] PARK      = '1;
  localparam logic [OW-1:0]         LAST_WR   = OW'(N - 1);
  localparam logic [RW-1:0]         LAST_ROW  = RW'(ROWS - 1);
  localparam logic [CW-1:0]         LAST_COL  = CW'(COLS - 1);
  localparam logic [OW-1:0]         COLS_STEP = OW'(COLS);

  // A block must fit in a bank with at least one spare location, so that
  // PARK stays free of data.
  if (N < 2 || N >= BANK) begin : g_size_check
    $fatal(1, "interl_ctrl: ROWS*COLS must satisfy 2 <= N < 2**(ADDR_WIDTH-1)");
  end

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic          wr_bank, wr_bank_n;
  logic          rd_bank, rd_bank_n;
  logic [1:0]    bank_full_n;
  logic [OW-1:0] wr_cnt, wr_cnt_n;
  logic [RW-1:0] rd_row, rd_row_n;
  logic [CW-1:0] rd_col, rd_col_n;
  logic [OW-1:0] rd_ofs, rd_ofs_n;
  logic          out_valid_n, out_bit_n, out_last_n;

  logic          accept;
  logic          advance;
  logic          rd_last;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      bank_full <= '0;
      wr_cnt    <= '0;
      rd_row    <= '0;
      rd_col    <= '0;
      rd_ofs    <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      wr_bank   <= wr_bank_n;
      rd_bank   <= rd_bank_n;
      bank_full <= bank_full_n;
      wr_cnt    <= wr_cnt_n;
      rd_row    <= rd_row_n;
      rd_col    <= rd_col_n;
      rd_ofs    <= rd_ofs_n;
      out_valid <= out_valid_n;
      out_bit   <= out_bit_n;
      out_last  <= out_last_n;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    wr_bank_n   = wr_bank;
    rd_bank_n   = rd_bank;
    bank_full_n = bank_full;
    wr_cnt_n    = wr_cnt;
    rd_row_n    = rd_row;
    rd_col_n    = rd_col;
    rd_ofs_n    = rd_ofs;
    out_valid_n = out_valid;
    out_bit_n   = out_bit;
    out_last_n  = out_last;

    rd_last = (rd_row == LAST_ROW) && (rd_col == LAST_COL);
    advance = bank_full[rd_bank] && (!out_valid || out_ready);

    // Write side: fill the current bank row-major. Completing a block
    // marks the bank full and moves on to the other bank.
    if (accept) begin
      if (wr_cnt == LAST_WR) begin
        wr_cnt_n             = '0;
        bank_full_n[wr_bank] = 1'b1;
        wr_bank_n            = ~wr_bank;
      end else begin
        wr_cnt_n = wr_cnt + OW'(1);
      end
    end

    // Read side: walk the full bank column-major. The linear offset
    // row*COLS + col steps by COLS down a column. At the bottom of a
    // column, it restarts at the next column index, so no multiplier is
    // needed. The write side only ever sets the flag of a bank that is
    // empty, and this side only clears the flag of a bank that is full, so
    // both updates to bank_full_n can apply in the same cycle.
    if (advance) begin
      out_bit_n   = ram_read_data;
      out_valid_n = 1'b1;
      out_last_n  = rd_last;
      if (rd_row != LAST_ROW) begin
        rd_row_n = rd_row + RW'(1);
        rd_ofs_n = rd_ofs + COLS_STEP;
      end else if (rd_last) begin
        rd_row_n             = '0;
        rd_col_n             = '0;
        rd_ofs_n             = '0;
        bank_full_n[rd_bank] = 1'b0;
        rd_bank_n            = ~rd_bank;
      end else begin
        rd_row_n = '0;
        rd_col_n = rd_col + CW'(1);
        rd_ofs_n = OW'(rd_col) + OW'(1);
      end
    end else if (out_valid && out_ready) begin
      out_valid_n = 1'b0;
      out_last_n  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Output / RAM address logic
  // ---------------------------------------------------------------------
  always_comb begin
    in_ready = !rst && !bank_full[wr_bank];
    accept   = in_valid && in_ready;

    // The RAM writes every cycle. Idle writes go to PARK with zero data.
    if (accept) begin
      wr_ram_counter = {wr_bank, wr_cnt};
      ram_bit_data   = in_bit;
    end else begin
      wr_ram_counter = PARK;
      ram_bit_data   = 1'b0;
    end

    r_ram_counter = {rd_bank, rd_ofs};
  end

endmodule
